// File: rtl/projectile_pool.sv
// projectile_pool: SLOTS-entry projectile manager with launch cooldown, screen wrap and expiry.
// Optional semi-auto fire is enabled by defining PROJECTILE_POOL_EDGE_FIRE_EN.

module projectile_pool #(
  parameter int SLOTS      = 4,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FRAC       = 6,
  parameter int SPEED_LOG2 = 2,
  parameter int LIFETIME   = 60,
  parameter int COOLDOWN   = 8,
  localparam int XW  = $clog2(WIDTH),
  localparam int YW  = $clog2(HEIGHT),
  localparam int CW  = $clog2(SLOTS + 1),
  localparam int SIW = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                fire,
  input  logic [XW-1:0]       origin_x,
  input  logic [YW-1:0]       origin_y,
  input  logic signed [17:0]  sin_val,
  input  logic signed [17:0]  cos_val,
  input  logic [SLOTS-1:0]    kill,
  output logic [SLOTS-1:0]    active,
  output logic [SLOTS*XW-1:0] pos_x,
  output logic [SLOTS*YW-1:0] pos_y,
  output logic [CW-1:0]       count,
  output logic                fire_ack,
  output logic [SIW-1:0]      fire_slot
);

  localparam int PXW = XW + FRAC;
  localparam int PYW = YW + FRAC;
  localparam int VW  = SPEED_LOG2 + FRAC + 2;
  localparam int EW  = 18 + SPEED_LOG2;
  localparam int AXW = ((PXW > VW) ? PXW : VW) + 2;
  localparam int AYW = ((PYW > VW) ? PYW : VW) + 2;
  localparam logic signed [AXW-1:0] X_SPAN = AXW'(WIDTH << FRAC);
  localparam logic signed [AYW-1:0] Y_SPAN = AYW'(HEIGHT << FRAC);
  localparam logic [7:0] LIFE_INIT = 8'(LIFETIME);
  localparam logic [7:0] CD_INIT   = 8'(COOLDOWN);

  // fire is a level request looked at only on frame_tick; fire_ack is a one-cycle
  // acknowledge coincident with the new active bit; there is no back-pressure.

  logic [SLOTS-1:0]      active_q, active_d;
  logic [PXW-1:0]        x_q [SLOTS];
  logic [PXW-1:0]        x_d [SLOTS];
  logic [PYW-1:0]        y_q [SLOTS];
  logic [PYW-1:0]        y_d [SLOTS];
  logic signed [VW-1:0]  vx_q [SLOTS];
  logic signed [VW-1:0]  vx_d [SLOTS];
  logic signed [VW-1:0]  vy_q [SLOTS];
  logic signed [VW-1:0]  vy_d [SLOTS];
  logic [7:0]            life_q [SLOTS];
  logic [7:0]            life_d [SLOTS];
  logic [7:0]            cd_q, cd_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  fire_ack_q, fire_ack_d;
  logic [SIW-1:0]        fire_slot_q, fire_slot_d;

  logic                  fire_qual;
  logic                  launch;
  logic [SIW-1:0]        free_idx;
  logic signed [EW-1:0]  cos_sh, sin_sh;
  logic signed [VW-1:0]  vx_new, vy_new;

  function automatic logic [PXW-1:0] step_x(input logic [PXW-1:0] p,
                                            input logic signed [VW-1:0] v);
    logic signed [AXW-1:0] s;
    s = AXW'(p) + AXW'(v);
    if (s[AXW-1])         s = s + X_SPAN;
    else if (s >= X_SPAN) s = s - X_SPAN;
    return PXW'(s);
  endfunction

  // Screen y grows downward, so a positive sine moves the projectile up.
  function automatic logic [PYW-1:0] step_y(input logic [PYW-1:0] p,
                                            input logic signed [VW-1:0] v);
    logic signed [AYW-1:0] s;
    s = AYW'(p) - AYW'(v);
    if (s[AYW-1])         s = s + Y_SPAN;
    else if (s >= Y_SPAN) s = s - Y_SPAN;
    return PYW'(s);
  endfunction

`ifdef PROJECTILE_POOL_EDGE_FIRE_EN
  logic fire_prev_q, fire_prev_d;

  always_comb begin
    fire_prev_d = fire_prev_q;
    if (frame_tick) fire_prev_d = fire;
  end

  assign fire_qual = fire & ~fire_prev_q;

  // Resets high so a trigger held through reset needs a release before it fires.
  always_ff @(posedge clk) begin
    if (reset) fire_prev_q <= 1'b1;
    else       fire_prev_q <= fire_prev_d;
  end
`else
  assign fire_qual = fire;
`endif

  // Scale the unit heading to px/frame in FRAC fixed point; >>> floors toward -inf.
  always_comb begin
    cos_sh = EW'(cos_val) <<< SPEED_LOG2;
    sin_sh = EW'(sin_val) <<< SPEED_LOG2;
    vx_new = VW'(cos_sh >>> (17 - FRAC));
    vy_new = VW'(sin_sh >>> (17 - FRAC));
  end

  // Eligibility uses the registered active vector, so slots freed this cycle wait a frame.
  always_comb begin
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) free_idx = SIW'(i);
    end
    launch = frame_tick && fire_qual && (cd_q == 8'd0) && !(&active_q);
  end

  always_comb begin
    active_d = active_q;
    for (int i = 0; i < SLOTS; i++) begin
      x_d[i]    = x_q[i];
      y_d[i]    = y_q[i];
      vx_d[i]   = vx_q[i];
      vy_d[i]   = vy_q[i];
      life_d[i] = life_q[i];
      if (active_q[i]) begin
        if (kill[i]) begin
          active_d[i] = 1'b0;
          life_d[i]   = 8'd0;
        end else if (frame_tick) begin
          x_d[i]    = step_x(x_q[i], vx_q[i]);
          y_d[i]    = step_y(y_q[i], vy_q[i]);
          life_d[i] = life_q[i] - 8'd1;
          if (life_q[i] == 8'd1) active_d[i] = 1'b0;
        end
      end else if (launch && (free_idx == SIW'(i))) begin
        active_d[i] = 1'b1;
        x_d[i]      = PXW'(origin_x) << FRAC;
        y_d[i]      = PYW'(origin_y) << FRAC;
        vx_d[i]     = vx_new;
        vy_d[i]     = vy_new;
        life_d[i]   = LIFE_INIT;
      end
    end
  end

  always_comb begin
    cd_d = cd_q;
    if (frame_tick) begin
      if (launch)             cd_d = CD_INIT;
      else if (cd_q != 8'd0)  cd_d = cd_q - 8'd1;
    end
    fire_ack_d  = launch;
    fire_slot_d = launch ? free_idx : fire_slot_q;
    count_d     = '0;
    for (int i = 0; i < SLOTS; i++) begin
      count_d = count_d + CW'(active_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q    <= '0;
      cd_q        <= 8'd0;
      count_q     <= '0;
      fire_ack_q  <= 1'b0;
      fire_slot_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        vx_q[i]   <= '0;
        vy_q[i]   <= '0;
        life_q[i] <= 8'd0;
      end
    end else begin
      active_q    <= active_d;
      cd_q        <= cd_d;
      count_q     <= count_d;
      fire_ack_q  <= fire_ack_d;
      fire_slot_q <= fire_slot_d;
      for (int i = 0; i < SLOTS; i++) begin
        x_q[i]    <= x_d[i];
        y_q[i]    <= y_d[i];
        vx_q[i]   <= vx_d[i];
        vy_q[i]   <= vy_d[i];
        life_q[i] <= life_d[i];
      end
    end
  end

  assign active    = active_q;
  assign count     = count_q;
  assign fire_ack  = fire_ack_q;
  assign fire_slot = fire_slot_q;

  for (genvar g = 0; g < SLOTS; g++) begin : g_pos
    assign pos_x[g*XW +: XW] = x_q[g][PXW-1:FRAC];
    assign pos_y[g*YW +: YW] = y_q[g][PYW-1:FRAC];
  end

endmodule

// File: tb/tb_projectile_pool.sv
// Bench for projectile_pool: directed vector table, corner-case sequences, and
// randomized traffic checked against an integer-arithmetic reference model.

module tb_projectile_pool;

  localparam int SLOTS      = 4;
  localparam int WIDTH      = 640;
  localparam int HEIGHT     = 480;
  localparam int FRAC       = 6;
  localparam int SPEED_LOG2 = 2;
  localparam int LIFETIME   = 60;
  localparam int COOLDOWN   = 2;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 3;
  localparam int SIW = 2;

  // clock / reset / stimulus signals
  logic clk = 1'b0;
  logic reset, frame_tick, fire;
  logic [XW-1:0] origin_x;
  logic [YW-1:0] origin_y;
  logic signed [17:0] sin_val, cos_val;
  logic [SLOTS-1:0] kill;

  logic [SLOTS-1:0]    active, active_l;
  logic [SLOTS*XW-1:0] pos_x, pos_x_l;
  logic [SLOTS*YW-1:0] pos_y, pos_y_l;
  logic [CW-1:0]       count, count_l;
  logic                fire_ack, fire_ack_l;
  logic [SIW-1:0]      fire_slot, fire_slot_l;

  always #5 clk = ~clk;

  projectile_pool #(
    .SLOTS(SLOTS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FRAC(FRAC),
    .SPEED_LOG2(SPEED_LOG2), .LIFETIME(LIFETIME), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .fire(fire),
    .origin_x(origin_x), .origin_y(origin_y), .sin_val(sin_val), .cos_val(cos_val),
    .kill(kill), .active(active), .pos_x(pos_x), .pos_y(pos_y), .count(count),
    .fire_ack(fire_ack), .fire_slot(fire_slot)
  );

  projectile_pool #(
    .SLOTS(SLOTS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FRAC(FRAC),
    .SPEED_LOG2(SPEED_LOG2), .LIFETIME(3), .COOLDOWN(0)
  ) dut_l (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .fire(fire),
    .origin_x(origin_x), .origin_y(origin_y), .sin_val(sin_val), .cos_val(cos_val),
    .kill(kill), .active(active_l), .pos_x(pos_x_l), .pos_y(pos_y_l), .count(count_l),
    .fire_ack(fire_ack_l), .fire_slot(fire_slot_l)
  );

  int n_vec = 0;
  int n_bad = 0;

  // reference model state (fixed-point ints, plain arithmetic)
  int m_x[SLOTS], m_y[SLOTS], m_vx[SLOTS], m_vy[SLOTS], m_life[SLOTS];
  bit m_act[SLOTS];
  int m_cd, m_slot;
  bit m_prev, m_ack;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int num, input int den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  function automatic int wrap(input int v, input int span);
    return ((v % span) + span) % span;
  endfunction

  task automatic model_step();
    int lo;
    bit qual, launch;
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_life[i] = 0; m_act[i] = 0;
      end
      m_cd = 0; m_slot = 0; m_ack = 0; m_prev = 1;
      return;
    end
`ifdef PROJECTILE_POOL_EDGE_FIRE_EN
    qual = fire && !m_prev;
`else
    qual = fire;
`endif
    lo = -1;
    for (int i = 0; i < SLOTS; i++) if (!m_act[i] && lo < 0) lo = i;
    launch = frame_tick && qual && (m_cd == 0) && (lo >= 0);
    for (int i = 0; i < SLOTS; i++) begin
      if (m_act[i]) begin
        if (kill[i]) m_act[i] = 0;
        else if (frame_tick) begin
          m_x[i] = wrap(m_x[i] + m_vx[i], WIDTH * (1 << FRAC));
          m_y[i] = wrap(m_y[i] - m_vy[i], HEIGHT * (1 << FRAC));
          m_life[i]--;
          if (m_life[i] == 0) m_act[i] = 0;
        end
      end else if (launch && i == lo) begin
        m_act[i]  = 1;
        m_x[i]    = int'(origin_x) * (1 << FRAC);
        m_y[i]    = int'(origin_y) * (1 << FRAC);
        m_vx[i]   = floor_div(int'(cos_val) * (1 << SPEED_LOG2), 1 << (17 - FRAC));
        m_vy[i]   = floor_div(int'(sin_val) * (1 << SPEED_LOG2), 1 << (17 - FRAC));
        m_life[i] = LIFETIME;
      end
    end
    if (frame_tick) begin
      if (launch) m_cd = COOLDOWN;
      else if (m_cd > 0) m_cd--;
      m_prev = fire;
    end
    m_ack = launch;
    if (launch) m_slot = lo;
  endtask

  task automatic check_model();
    int av, cn;
    av = 0; cn = 0;
    for (int i = 0; i < SLOTS; i++) begin
      av |= int'(m_act[i]) << i;
      cn += int'(m_act[i]);
    end
    chk("m_active", int'(active), av);
    chk("m_count", int'(count), cn);
    chk("m_fire_ack", int'(fire_ack), int'(m_ack));
    chk("m_fire_slot", int'(fire_slot), m_slot);
    for (int i = 0; i < SLOTS; i++) begin
      chk("m_pos_x", int'(pos_x[i*XW +: XW]), m_x[i] / (1 << FRAC));
      chk("m_pos_y", int'(pos_y[i*YW +: YW]), m_y[i] / (1 << FRAC));
    end
  endtask

  // driver tasks
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_tick = 1'b0; kill = '0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic tick(input bit f, input logic [SLOTS-1:0] k);
    frame_tick = 1'b1; fire = f; kill = k;
    cycle();
    frame_tick = 1'b0; kill = '0;
  endtask

  typedef struct {
    bit rst; bit tk; bit fr; int ox; int oy; int sn; int cs; int kl;
    int e_act; int e_cnt; int e_ack; int e_slot; int e_px0; int e_py0;
  } vec_t;

  vec_t tbl[$];
  int acks;

  initial begin
    reset = 1'b1; frame_tick = 1'b0; fire = 1'b0; kill = '0;
    origin_x = '0; origin_y = '0; sin_val = '0; cos_val = '0;

    //             rst tk fr  ox   oy  sn      cs       kl  act    cnt ack slot px0  py0
    tbl.push_back('{1, 0, 0, 100, 200, 0,      131071,  0,  0,     0,  0,  0,   0,   0});
    tbl.push_back('{0, 1, 0, 100, 200, 0,      131071,  0,  0,     0,  0,  0,   0,   0});
    tbl.push_back('{0, 1, 1, 100, 200, 0,      131071,  0,  1,     1,  1,  0,   100, 200});
    tbl.push_back('{0, 0, 0, 100, 200, 0,      131071,  0,  1,     1,  0,  0,   100, 200});
    tbl.push_back('{0, 1, 0, 100, 200, 0,      131071,  0,  1,     1,  0,  0,   103, 200});
    tbl.push_back('{0, 0, 0, 100, 200, 0,      131071,  1,  0,     0,  0,  0,   103, 200});
    tbl.push_back('{1, 0, 0, 639, 0,   131071, 131071,  0,  0,     0,  0,  0,   0,   0});
    tbl.push_back('{0, 1, 0, 639, 0,   131071, 131071,  0,  0,     0,  0,  0,   0,   0});
    tbl.push_back('{0, 1, 1, 639, 0,   131071, 131071,  0,  1,     1,  1,  0,   639, 0});
    tbl.push_back('{0, 1, 0, 639, 0,   131071, 131071,  0,  1,     1,  0,  0,   2,   476});
    tbl.push_back('{0, 1, 0, 639, 0,   131071, 131071,  0,  1,     1,  0,  0,   6,   472});
    tbl.push_back('{0, 1, 1, 639, 0,   131071, 131071,  0,  3,     2,  1,  1,   10,  468});
    tbl.push_back('{0, 0, 0, 639, 0,   131071, 131071,  8,  3,     2,  0,  1,   10,  468});

    foreach (tbl[v]) begin
      reset = tbl[v].rst; frame_tick = tbl[v].tk; fire = tbl[v].fr;
      origin_x = XW'(tbl[v].ox); origin_y = YW'(tbl[v].oy);
      sin_val = 18'(tbl[v].sn); cos_val = 18'(tbl[v].cs); kill = SLOTS'(tbl[v].kl);
      cycle();
      chk("t_active", int'(active), tbl[v].e_act);
      chk("t_count", int'(count), tbl[v].e_cnt);
      chk("t_fire_ack", int'(fire_ack), tbl[v].e_ack);
      chk("t_fire_slot", int'(fire_slot), tbl[v].e_slot);
      chk("t_pos_x0", int'(pos_x[XW-1:0]), tbl[v].e_px0);
      chk("t_pos_y0", int'(pos_y[YW-1:0]), tbl[v].e_py0);
    end

    origin_x = 10'd320; origin_y = 9'd240; sin_val = '0; cos_val = '0;

`ifndef PROJECTILE_POOL_EDGE_FIRE_EN
    // auto-fire rate limited by cooldown until the pool fills
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      tick(1'b1, '0);
      chk("auto_ack", int'(fire_ack), ((k % 3 == 0) && (k <= 9)) ? 1 : 0);
      if ((k % 3 == 0) && (k <= 9)) chk("auto_slot", int'(fire_slot), k / 3);
      fire = 1'b0;
      cycle();
    end
    chk("auto_full_count", int'(count), 4);
    chk("auto_full_active", int'(active), 15);
`else
    // semi-auto: held through reset never fires; one ack per press
    fire = 1'b1;
    do_reset();
    tick(1'b1, '0);
    chk("edge_held_reset", int'(fire_ack), 0);
    tick(1'b0, '0);
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, '0);
      acks += int'(fire_ack);
    end
    chk("edge_one_ack", acks, 1);
    tick(1'b0, '0);
    tick(1'b1, '0);
    chk("edge_repress_ack", int'(fire_ack), 1);
`endif

    // lifetime 3 on the second instance
    fire = 1'b0;
    do_reset();
    tick(1'b0, '0);
    tick(1'b1, '0);
    chk("life_launch", int'(active_l), 1);
    chk("life_count", int'(count_l), 1);
    tick(1'b0, '0);
    chk("life_t1", int'(active_l), 1);
    tick(1'b0, '0);
    chk("life_t2", int'(active_l), 1);
    tick(1'b0, '0);
    chk("life_t3_active", int'(active_l), 0);
    chk("life_t3_count", int'(count_l), 0);

    // kill on a slot coinciding with a launch: freed slot is skipped
    do_reset();
    tick(1'b0, '0);
    tick(1'b1, '0);
    chk("kill_seq_slot0", int'(fire_slot), 0);
    tick(1'b0, '0);
    tick(1'b0, '0);
    tick(1'b1, '0);
    chk("kill_seq_ack1", int'(fire_ack), 1);
    chk("kill_seq_slot1", int'(fire_slot), 1);
    tick(1'b0, '0);
    tick(1'b0, '0);
    tick(1'b1, 4'b0010);
    chk("kill_active", int'(active), 5);
    chk("kill_ack", int'(fire_ack), 1);
    chk("kill_fire_slot", int'(fire_slot), 2);
    chk("kill_count", int'(count), 2);

    // randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      fire       = 1'($urandom_range(0, 1));
      kill       = ($urandom_range(0, 7) == 0) ? SLOTS'($urandom_range(0, 15)) : '0;
      origin_x   = XW'($urandom_range(0, WIDTH - 1));
      origin_y   = YW'($urandom_range(0, HEIGHT - 1));
      case ($urandom_range(0, 3))
        0:       cos_val = 18'sh1FFFF;
        1:       cos_val = 18'sh20000;
        default: cos_val = 18'($urandom);
      endcase
      sin_val = ($urandom_range(0, 3) == 0) ? 18'sh20000 : 18'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
